// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: responder-side controller for one gf180mcu 512x8 SRAM macro
// (sram512x8m8wm1 pin protocol). Requests arrive on a valid/ready channel, macro
// pins are driven combinationally in the acceptance cycle, and read data comes
// back two cycles later through a small credit-managed response FIFO.
// Optional feature macro: SRAM_CLR_EN (zero-fill sweep of the whole macro after reset).
module sram_port_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 8,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_cen,
  output logic              sram_gwen,
  output logic [DATA_W-1:0] sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  output logic              busy
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic {INIT, IDLE} state_t;

  state_t            state;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [RSP_DEPTH];
  logic [CW:0]       credit;
  logic              accept;
  logic              push;
  logic              pop;

`ifdef SRAM_CLR_EN
  logic [ADDR_W-1:0] clr_addr;
`endif

  // Handshake and credit: a read is only taken when its response is guaranteed a FIFO slot
  assign pop       = rsp_valid && rsp_ready;
  assign push      = inflight;
  assign credit    = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign req_ready = !rst && (state == IDLE) && (credit < (CW+1)'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign busy      = rst || (state == INIT);
  assign rsp_valid = (count != '0);
  assign rsp_rdata = rsp_valid ? mem[rd_ptr] : '0;

  // Macro pin drive: clear sweep, accepted read, accepted write, else deselected
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
`ifdef SRAM_CLR_EN
    if (!rst && state == INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = clr_addr;
    end else
`endif
    if (accept && !req_we) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
    end else if (accept && req_we && (req_wmask != '0)) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~req_wmask;
      sram_a    = req_addr;
      sram_d    = req_wdata;
    end
  end

  // Controller state: optional clear sweep, then serve requests until the next reset
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef SRAM_CLR_EN
      state    <= INIT;
      clr_addr <= '0;
`else
      state    <= IDLE;
`endif
    end else begin
`ifdef SRAM_CLR_EN
      if (state == INIT) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == {ADDR_W{1'b1}}) begin
          state <= IDLE;
        end
      end
`endif
    end
  end

  // Read pipeline and FIFO bookkeeping: Q is valid the cycle after the access
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= accept && !req_we;
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= sram_q;
    end
  end

endmodule
